// File: rtl/dff_pipe_pkg.sv
// rtl/dff_pipe_pkg.sv - default sizes and count-width helper for dff_pipe
package dff_pipe_pkg;

    localparam int DFF_PIPE_WIDTH = 8;
    localparam int DFF_PIPE_DEPTH = 4;

    // Occupancy runs 0..depth inclusive, hence depth+1 codes.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// rtl/dff_pipe_stage.sv - one data+valid stage; async clear, sync preset when DFF_PIPE_SET_EN is defined
module dff_pipe_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic             clk,
    input  logic             clear,
`ifdef DFF_PIPE_SET_EN
    input  logic             set,
`endif
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             valid_d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q     <= '0;
            valid <= 1'b0;
        end
`ifdef DFF_PIPE_SET_EN
        else if (set) begin
            q     <= SET_VAL;
            valid <= 1'b1;
        end
`endif
        else begin
            // Data only moves on load so a stalled or emptied stage keeps its bits.
            if (load) begin
                q <= d;
            end
            valid <= valid_d;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - elastic register pipeline with bubble collapse; set port when DFF_PIPE_SET_EN is defined
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH   = DFF_PIPE_WIDTH,
    parameter int               DEPTH   = DFF_PIPE_DEPTH,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic                          clk,
    input  logic                          clear,
`ifdef DFF_PIPE_SET_EN
    input  logic                          set,
`endif
    input  logic [WIDTH-1:0]              d,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] move;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] valid_d;
    logic             accept0;
    logic             hold;
    logic             push;
    logic             pop;

`ifdef DFF_PIPE_SET_EN
    assign hold = clear | set;
`else
    assign hold = clear;
`endif

    // Ready ripples from the output back to the input in the same cycle.
    always_comb begin
        logic acc;
        acc  = out_ready;
        move = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            move[k] = valid[k] & acc;
            acc     = ~valid[k] | move[k];
        end
        accept0 = acc;
    end

    assign in_ready  = accept0 & ~hold;
    assign out_valid = valid[DEPTH-1] & ~hold;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign q         = data[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign load[k] = push;
        end else begin : g_next
            assign load[k] = move[k-1];
        end
        assign valid_d[k] = load[k] | (valid[k] & ~move[k]);

        dff_pipe_stage #(
            .WIDTH   (WIDTH),
            .SET_VAL (SET_VAL)
        ) u_stage (
            .clk     (clk),
            .clear   (clear),
`ifdef DFF_PIPE_SET_EN
            .set     (set),
`endif
            .load    (load[k]),
            .d       ((k == 0) ? d : data[(k == 0) ? 0 : k-1]),
            .valid_d (valid_d[k]),
            .q       (data[k]),
            .valid   (valid[k])
        );
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count <= '0;
        end
`ifdef DFF_PIPE_SET_EN
        else if (set) begin
            count <= CW'(DEPTH);
        end
`endif
        else begin
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - directed checks for dff_pipe (WIDTH=8, DEPTH=4, SET_VAL=8'h5A)
module tb_dff_pipe;

    logic       clk;
    logic       clear;
`ifdef DFF_PIPE_SET_EN
    logic       set;
`endif
    logic [7:0] d;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] q;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    dff_pipe #(
        .WIDTH   (8),
        .DEPTH   (4),
        .SET_VAL (8'h5A)
    ) dut (
        .clk       (clk),
        .clear     (clear),
`ifdef DFF_PIPE_SET_EN
        .set       (set),
`endif
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        d = 8'h77; tick;
        d = 8'h78; tick;
        in_valid = 1'b0;
        clear = 1'b1;
        #1;
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q: got %h expected 00", q); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_during: got %b expected 0", in_ready); end
        clear = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            in_valid = (n <= 8);
            d        = 8'h11 + 8'(n - 1);
            #1;
            if (n <= 8) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", n, in_ready); end
            end
            tick;
            if (n >= 4 && n <= 11) begin
                checks++;
                if (out_valid !== 1'b1 || q !== 8'h11 + 8'(n - 4)) begin
                    failures++;
                    $display("FAIL stream_q[%0d]: got v=%b q=%h expected v=1 q=%h", n, out_valid, q, 8'h11 + 8'(n - 4));
                end
            end else begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_idle[%0d]: got v=%b expected 0", n, out_valid); end
            end
            if (n <= 8) begin
                checks++;
                if (count !== ((n < 4) ? 3'(n) : 3'd4)) begin
                    failures++;
                    $display("FAIL stream_count[%0d]: got %0d expected %0d", n, count, (n < 4) ? n : 4);
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL stream_drained: got %0d expected 0", count); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = 8'h11 + 8'(i);
            #1;
            checks++;
            if (in_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, in_ready, (i < 4));
            end
            tick;
        end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_full_count: got %0d expected 4", count); end
        checks++; if (out_valid !== 1'b1 || q !== 8'h11) begin failures++; $display("FAIL bp_head: got v=%b q=%h expected v=1 q=11", out_valid, q); end
        out_ready = 1'b1;
        d = 8'h15;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_full_ready: got %b expected 1", in_ready); end
        tick;
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_swap_count: got %0d expected 4", count); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_valid !== 1'b1 || q !== 8'h12 + 8'(j)) begin
                failures++;
                $display("FAIL bp_drain[%0d]: got v=%b q=%h expected v=1 q=%h", j, out_valid, q, 8'h12 + 8'(j));
            end
            tick;
        end
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL bp_empty: got v=%b count=%0d expected v=0 count=0", out_valid, count); end
    endtask

    task automatic test_bubble;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        d = 8'hA1; tick;
        in_valid = 1'b0;
        tick; tick;
        in_valid = 1'b1;
        d = 8'hA2; tick;
        in_valid = 1'b0;
        tick; tick;
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL bubble_count: got %0d expected 2", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b1 || q !== 8'hA1) begin failures++; $display("FAIL bubble_head: got v=%b q=%h expected v=1 q=a1", out_valid, q); end
        out_ready = 1'b1;
        tick;
        checks++; if (out_valid !== 1'b1 || q !== 8'hA2) begin failures++; $display("FAIL bubble_second: got v=%b q=%h expected v=1 q=a2", out_valid, q); end
        tick;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL bubble_empty: got v=%b count=%0d expected v=0 count=0", out_valid, count); end
    endtask

    task automatic test_clear_midflight;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = 8'hC1 + 8'(i);
            tick;
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL clr_pre_count: got %0d expected 3", count); end
        clear = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL clr_async: got count=%0d v=%b expected 0 0", count, out_valid); end
        clear = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        d = 8'hD1;
        #1;
        tick;
        in_valid = 1'b0;
        tick; tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_latency_early: got v=%b expected 0", out_valid); end
        tick;
        checks++; if (out_valid !== 1'b1 || q !== 8'hD1) begin failures++; $display("FAIL clr_latency: got v=%b q=%h expected v=1 q=d1", out_valid, q); end
        tick;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL clr_final_count: got %0d expected 0", count); end
    endtask

`ifdef DFF_PIPE_SET_EN
    task automatic test_set;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        d = 8'hE1; tick;
        d = 8'hE2; tick;
        set = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL set_block: got rdy=%b v=%b expected 0 0", in_ready, out_valid); end
        tick;
        set = 1'b0;
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL set_count: got %0d expected 4", count); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_valid !== 1'b1 || q !== 8'h5A) begin
                failures++;
                $display("FAIL set_pop[%0d]: got v=%b q=%h expected v=1 q=5a", j, out_valid, q);
            end
            tick;
        end
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL set_empty: got v=%b count=%0d expected 0 0", out_valid, count); end
    endtask
`endif

    initial begin
        clear     = 1'b1;
`ifdef DFF_PIPE_SET_EN
        set       = 1'b0;
`endif
        d         = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick; tick;
        clear = 1'b0;
        #1;
        test_reset;
        test_stream;
        test_backpressure;
        test_bubble;
        test_clear_midflight;
`ifdef DFF_PIPE_SET_EN
        test_set;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, >=1.
REQ-002 Parameter DEPTH, default 4: number of register stages, >=1.
REQ-003 Parameter SET_VAL, default all-ones of WIDTH: value loaded into every stage by set.
REQ-004 clk  input  1  single clock; all state changes on the rising edge, except clear.
REQ-005 clear  input  1  asynchronous, active-high reset.
REQ-006 set  input  1  synchronous preset; present only when DFF_PIPE_SET_EN is defined.
REQ-007 d  input  WIDTH  upstream data.
REQ-008 in_valid  input  1  upstream data valid.
REQ-009 in_ready  output  1  block accepts d this cycle.
REQ-010 q  output  WIDTH  downstream data; meaningful only while out_valid=1.
REQ-011 out_valid  output  1  q holds an item.
REQ-012 out_ready  input  1  downstream accepts q this cycle.
REQ-013 count  output  $clog2(DEPTH+1)  number of occupied stages, registered.

Function
REQ-014 Stages are indexed 0 (input) to DEPTH-1 (output); each stage holds WIDTH data bits and one valid bit.
REQ-015 Push = in_valid & in_ready, sampled at the rising edge; pop = out_valid & out_ready, sampled at the rising edge.
REQ-016 accept[DEPTH] = out_ready; move[k] = valid[k] & accept[k+1]; accept[k] = !valid[k] | move[k]; in_ready = accept[0]; combinational ready path, no bubble cycle.
REQ-017 On a move, stage k+1 takes stage k data and valid=1; a stage that is not refilled clears its valid; data of an invalid stage is don't-care but is not altered by stalls.
REQ-018 Bubble collapse: items advance into empty downstream stages even while out_ready=0.
REQ-019 Latency: an item pushed into an empty pipe has out_valid=1 after DEPTH-1 further rising edges; DEPTH=1 behaves as a single handshaked register.
REQ-020 Throughput: one item per cycle while in_valid=1 and out_ready=1.
REQ-021 Full (count=DEPTH) with out_ready=0: in_ready=0. Full with out_ready=1: push and pop in the same cycle, count unchanged.
REQ-022 Empty: out_valid=0, in_ready=1.
REQ-023 count_next = count + push - pop; it never exceeds DEPTH and never wraps.
REQ-024 Order is preserved: no item is dropped or duplicated.

Reset
REQ-025 clear=1 immediately, without a clock edge, forces all valid=0, all data=0, count=0, q=0.
REQ-026 While clear=1, in_ready=0 and out_valid=0; in_ready=1 from the first cycle after deassertion.
REQ-027 clear asserted mid-transfer discards all items in flight; clear has priority over set and over the handshake.

Configuration
REQ-028 Macro DFF_PIPE_SET_EN defined: set port exists. set=1 at an edge loads SET_VAL into every stage with valid=1 and sets count=DEPTH. While set=1, in_ready=0 and out_valid=0, so no transfer occurs. set takes priority over the handshake.
REQ-029 DFF_PIPE_SET_EN undefined: no set port and no preset logic; all other behaviour is identical.

Structure
REQ-030 Package dff_pipe_pkg holds the default WIDTH and DEPTH constants and a count-width function, clog2(DEPTH+1).
REQ-031 Sub-module dff_pipe_stage: one data+valid register with async clear, optional sync set and load enable. dff_pipe instantiates it DEPTH times via generate.

Verification (WIDTH=8, DEPTH=4, SET_VAL=8'h5A)
REQ-032 Pulse clear between edges -> q=8'h00, out_valid=0, count=0 immediately; in_ready=1 after deassertion.
REQ-033 Stream 8'h11..8'h18 with out_ready=1 held -> 8'h11 on q 3 edges after its push, then one item per cycle in order, count=3 or 4 in steady state.
REQ-034 out_ready=0, offer 5 items -> 4 accepted, in_ready=0, count=4; then out_ready=1 for one cycle with in_valid=1 -> 8'h11 popped, 5th item pushed, count stays 4.
REQ-035 Push 8'hA1, idle 2 cycles, push 8'hA2, out_ready=0 -> A1 in stage 3 and A2 in stage 2, count=2, in_ready=1.
REQ-036 With DFF_PIPE_SET_EN defined, set=1 for one edge mid-stream -> count=4, q=8'h5A; the next 4 pops all return 8'h5A.
REQ-037 clear asserted with count=3 -> count=0 without a clock edge; the next push appears on q after 3 edges.
